// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer: upstream ready is
// registered, so a downstream stall never forms a combinational path upstream.
module pipe_stage_skid #(
  parameter int WIDTH          = 237,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready depends only on state.

  // The state value doubles as the entry count, so occupancy exposes the FSM.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] mainData, mainNext;
  logic [WIDTH-1:0] skidData, skidNext;
  logic             accept, pop;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = mainData;
  assign occupancy = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    stateNext = state;
    mainNext  = mainData;
    skidNext  = skidData;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          mainNext  = in_data;
          stateNext = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          mainNext = in_data;
        end else if (accept) begin
          skidNext  = in_data;
          stateNext = TWO;
        end else if (pop) begin
          stateNext = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          mainNext  = skidData;
          stateNext = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Flush drops everything, including an entry handed over this same cycle.
    if (flush) begin
      stateNext = EMPTY;
      mainNext  = CLEAR_ON_FLUSH ? '0 : mainData;
      skidNext  = CLEAR_ON_FLUSH ? '0 : skidData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      mainData <= '0;
      skidData <= '0;
    end else begin
      state    <= stateNext;
      mainData <= mainNext;
      skidData <= skidNext;
    end
  end

endmodule
